// File: rtl/eclock_pkg.sv
// Shared definitions for the E clock generator: default timing constants
// and the peripheral request FSM state encoding.
package eclock_pkg;

  localparam int E_LOW_DEF      = 6;
  localparam int E_HIGH_DEF     = 4;
  localparam int SYNC_POINT_DEF = 2;
  localparam int CW_DEF         = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SYNC  = 2'd1,
    ST_VMA_ACTIVE = 2'd2,
    ST_HOLD       = 2'd3
  } req_state_t;

endpackage

// File: rtl/eclock_phase_counter.sv
// Free-running phase counter (0..DIV-1) with registered E clock decode,
// aligned so that eclock is high exactly while phase is in E_LOW..DIV-1.
module eclock_phase_counter #(
  parameter int E_LOW  = 6,
  parameter int E_HIGH = 4,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] phase,
  output logic          eclock
);

  localparam int            DIV     = E_LOW + E_HIGH;
  localparam logic [CW-1:0] LAST_PH = CW'(DIV - 1);
  localparam logic [CW-1:0] HIGH_PH = CW'(E_LOW);

  logic [CW-1:0] phase_next;

  // Next phase with wrap at the end of the period.
  always_comb begin
    phase_next = (phase == LAST_PH) ? {CW{1'b0}} : phase + {{(CW-1){1'b0}}, 1'b1};
  end

  // eclock is decoded from the next phase so it lines up with the phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= {CW{1'b0}};
      eclock <= 1'b0;
    end else begin
      phase  <= phase_next;
      eclock <= (phase_next >= HIGH_PH);
    end
  end

endmodule

// File: rtl/eclock_gen.sv
// 6800-style E clock generator with synchronous peripheral cycle (VMA) sequencing.
// Optional macro ECLOCK_GEN_EDGE_STROBE_EN enables the E edge strobe outputs.
module eclock_gen
  import eclock_pkg::*;
#(
  parameter int E_LOW      = E_LOW_DEF,
  parameter int E_HIGH     = E_HIGH_DEF,
  parameter int SYNC_POINT = SYNC_POINT_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic CLOCK_IN,
  input  logic RESET_IN,
  input  logic VPA_REQ_IN,
  output logic ECLOCK_OUT,
  output logic VMA_OUT,
  output logic DONE_OUT,
  output logic E_RISE_OUT,
  output logic E_FALL_OUT
);

  localparam int            DIV     = E_LOW + E_HIGH;
  localparam logic [CW-1:0] LAST_PH = CW'(DIV - 1);
  localparam logic [CW-1:0] SYNC_PH = CW'(SYNC_POINT);

  if (E_LOW < 2 || E_HIGH < 1 || SYNC_POINT >= E_LOW - 1 || (2 ** CW) < DIV) begin : g_param_check
    $error("eclock_gen: illegal parameter combination");
  end

  logic [CW-1:0] phase;
  req_state_t    state;
  req_state_t    state_next;
  logic          vma_next;
  logic          done_next;

  eclock_phase_counter #(
    .E_LOW  (E_LOW),
    .E_HIGH (E_HIGH),
    .CW     (CW)
  ) u_phase (
    .clk    (CLOCK_IN),
    .rst    (RESET_IN),
    .phase  (phase),
    .eclock (ECLOCK_OUT)
  );

  // Request sequencing; commit only at SYNC_POINT so VMA stays inside the E high/low window.
  always_comb begin
    state_next = state;
    vma_next   = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (VPA_REQ_IN) state_next = ST_WAIT_SYNC;
        else            state_next = ST_IDLE;
      end
      ST_WAIT_SYNC: begin
        if (!VPA_REQ_IN) begin
          state_next = ST_IDLE;
        end else if (phase == SYNC_PH) begin
          state_next = ST_VMA_ACTIVE;
          vma_next   = 1'b1;
        end else begin
          state_next = ST_WAIT_SYNC;
        end
      end
      ST_VMA_ACTIVE: begin
        if (phase == LAST_PH) begin
          state_next = ST_HOLD;
          done_next  = 1'b1;
        end else begin
          state_next = ST_VMA_ACTIVE;
          vma_next   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!VPA_REQ_IN) state_next = ST_IDLE;
        else             state_next = ST_HOLD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state and registered peripheral strobes.
  always_ff @(posedge CLOCK_IN) begin
    if (RESET_IN) begin
      state    <= ST_IDLE;
      VMA_OUT  <= 1'b0;
      DONE_OUT <= 1'b0;
    end else begin
      state    <= state_next;
      VMA_OUT  <= vma_next;
      DONE_OUT <= done_next;
    end
  end

`ifdef ECLOCK_GEN_EDGE_STROBE_EN
  localparam logic [CW-1:0] PRE_RISE_PH = CW'(E_LOW - 1);

  // Edge strobes land on the same cycle as the phase they mark.
  always_ff @(posedge CLOCK_IN) begin
    if (RESET_IN) begin
      E_RISE_OUT <= 1'b0;
      E_FALL_OUT <= 1'b0;
    end else begin
      E_RISE_OUT <= (phase == PRE_RISE_PH);
      E_FALL_OUT <= (phase == LAST_PH);
    end
  end
`else
  assign E_RISE_OUT = 1'b0;
  assign E_FALL_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_eclock_gen.sv
// Directed self-checking bench for eclock_gen: default instance plus a
// short-period (3/2, sync 1) instance for pattern and edge strobe checks.
module tb_eclock_gen;

`ifdef ECLOCK_GEN_EDGE_STROBE_EN
  localparam bit STROBE = 1'b1;
`else
  localparam bit STROBE = 1'b0;
`endif

  logic clk;
  logic rst;
  logic vpa;
  logic vpa2;
  logic eclk, vma, done, rise, fall;
  logic eclk2, vma2, done2, rise2, fall2;

  int errors;
  int checks;

  eclock_gen dut (
    .CLOCK_IN   (clk),
    .RESET_IN   (rst),
    .VPA_REQ_IN (vpa),
    .ECLOCK_OUT (eclk),
    .VMA_OUT    (vma),
    .DONE_OUT   (done),
    .E_RISE_OUT (rise),
    .E_FALL_OUT (fall)
  );

  eclock_gen #(.E_LOW(3), .E_HIGH(2), .SYNC_POINT(1), .CW(4)) dut2 (
    .CLOCK_IN   (clk),
    .RESET_IN   (rst),
    .VPA_REQ_IN (vpa2),
    .ECLOCK_OUT (eclk2),
    .VMA_OUT    (vma2),
    .DONE_OUT   (done2),
    .E_RISE_OUT (rise2),
    .E_FALL_OUT (fall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at the negedge of the first post-reset cycle (phase 0).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    vpa = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (eclk !== 1'b0) begin errors++; $display("FAIL reset_eclock got=%b exp=0", eclk); end
    checks++; if (vma  !== 1'b0) begin errors++; $display("FAIL reset_vma got=%b exp=0", vma); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rise !== 1'b0) begin errors++; $display("FAIL reset_rise got=%b exp=0", rise); end
    checks++; if (fall !== 1'b0) begin errors++; $display("FAIL reset_fall got=%b exp=0", fall); end
    checks++; if (fall2 !== 1'b0) begin errors++; $display("FAIL reset_fall2 got=%b exp=0", fall2); end
  endtask

  task automatic test_idle_pattern();
    do_reset();
    for (int c = 0; c < 100; c++) begin
      logic e_exp, r_exp, f_exp, e2_exp, r2_exp, f2_exp;
      e_exp  = ((c % 10) >= 6);
      r_exp  = STROBE && ((c % 10) == 6);
      f_exp  = STROBE && ((c % 10) == 0) && (c > 0);
      e2_exp = ((c % 5) >= 3);
      r2_exp = STROBE && ((c % 5) == 3);
      f2_exp = STROBE && ((c % 5) == 0) && (c > 0);
      checks++; if (eclk !== e_exp) begin errors++; $display("FAIL idle_eclock cyc=%0d got=%b exp=%b", c, eclk, e_exp); end
      checks++; if ({vma, done} !== 2'b00) begin errors++; $display("FAIL idle_vma_done cyc=%0d got=%b exp=00", c, {vma, done}); end
      checks++; if ({rise, fall} !== {r_exp, f_exp}) begin errors++; $display("FAIL idle_strobes cyc=%0d got=%b exp=%b", c, {rise, fall}, {r_exp, f_exp}); end
      checks++; if (eclk2 !== e2_exp) begin errors++; $display("FAIL short_eclock cyc=%0d got=%b exp=%b", c, eclk2, e2_exp); end
      checks++; if ({rise2, fall2} !== {r2_exp, f2_exp}) begin errors++; $display("FAIL short_strobes cyc=%0d got=%b exp=%b", c, {rise2, fall2}, {r2_exp, f2_exp}); end
      checks++; if ({vma2, done2} !== 2'b00) begin errors++; $display("FAIL short_vma_done cyc=%0d got=%b exp=00", c, {vma2, done2}); end
      @(negedge clk);
    end
  endtask

  // Request at phase 0, held through a second period (no repeat), dropped, then re-raised at phase 1.
  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      logic v_exp, d_exp;
      v_exp = (c >= 3 && c <= 9) || (c >= 23 && c <= 29);
      d_exp = (c == 10) || (c == 30);
      checks++; if (vma !== v_exp) begin errors++; $display("FAIL b2b_vma cyc=%0d got=%b exp=%b", c, vma, v_exp); end
      checks++; if (done !== d_exp) begin errors++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", c, done, d_exp); end
      checks++; if (eclk !== ((c % 10) >= 6)) begin errors++; $display("FAIL b2b_eclock cyc=%0d got=%b", c, eclk); end
      vpa = (c < 20) || (c >= 21);
      @(negedge clk);
    end
    vpa = 1'b0;
  endtask

  // Request first seen at phase 5 waits for the next period; drop during VMA does not abort.
  task automatic test_late_request();
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      logic v_exp, d_exp;
      v_exp = (c >= 13 && c <= 19);
      d_exp = (c == 20);
      checks++; if (vma !== v_exp) begin errors++; $display("FAIL late_vma cyc=%0d got=%b exp=%b", c, vma, v_exp); end
      checks++; if (done !== d_exp) begin errors++; $display("FAIL late_done cyc=%0d got=%b exp=%b", c, done, d_exp); end
      vpa = (c >= 5) && (c < 15);
      @(negedge clk);
    end
    vpa = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      checks++; if ({vma, done} !== 2'b00) begin errors++; $display("FAIL abort_vma_done cyc=%0d got=%b exp=00", c, {vma, done}); end
      vpa = (c == 0);
      @(negedge clk);
    end
    vpa = 1'b0;
  endtask

  task automatic test_drop_phase5();
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      logic v_exp, d_exp;
      v_exp = (c >= 3 && c <= 9);
      d_exp = (c == 10);
      checks++; if (vma !== v_exp) begin errors++; $display("FAIL drop5_vma cyc=%0d got=%b exp=%b", c, vma, v_exp); end
      checks++; if (done !== d_exp) begin errors++; $display("FAIL drop5_done cyc=%0d got=%b exp=%b", c, done, d_exp); end
      vpa = (c < 5);
      @(negedge clk);
    end
    vpa = 1'b0;
  endtask

  task automatic test_reset_mid_cycle();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      logic v_exp;
      v_exp = (c >= 3);
      checks++; if (vma !== v_exp) begin errors++; $display("FAIL midrst_vma cyc=%0d got=%b exp=%b", c, vma, v_exp); end
      vpa = 1'b1;
      if (c == 6) begin
        rst = 1'b1;
        vpa = 1'b0;
      end else begin
        rst = 1'b0;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      logic e_exp;
      e_exp = ((k % 10) >= 6);
      checks++; if (eclk !== e_exp) begin errors++; $display("FAIL midrst_eclock cyc=%0d got=%b exp=%b", k, eclk, e_exp); end
      checks++; if ({vma, done} !== 2'b00) begin errors++; $display("FAIL midrst_vma_done cyc=%0d got=%b exp=00", k, {vma, done}); end
      @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    vpa    = 1'b0;
    vpa2   = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_idle_pattern();
    test_back_to_back();
    test_late_request();
    test_abort();
    test_drop_phase5();
    test_reset_mid_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
